id_ex_reg: RTL and testbench

ID/EX pipeline register with integrated load-use hazard detection, sitting directly downstream of the immediate extender and register-file read in the decode stage. Each cycle it captures the decoded instruction bundle (PC, IR, operand data, extended immediate, destination and control bits) and presents it to the EX stage. It inserts a bubble and requests an upstream hold on a load-use hazard, honours an external stall, and discards its contents on a branch/jump redirect flush.

---
 rtl/id_ex_reg.sv | 129 ++++++++++++
 tb/tb_id_ex_reg.sv | 217 +++++++++++++++++++++
 2 files changed

// File: rtl/id_ex_reg.sv
// ID/EX pipeline register with load-use hazard bubble insertion, external stall hold and redirect flush.
// Optional macro ID_EX_STATS_EN adds saturating bubble/flush/stall counters.
module id_ex_reg #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             id_valid,
  input  logic [31:0]      id_pc,
  input  logic [31:0]      id_ir,
  input  logic [31:0]      id_rs_data,
  input  logic [31:0]      id_rt_data,
  input  logic [31:0]      id_extdata,
  input  logic [4:0]       id_rs_addr,
  input  logic [4:0]       id_rt_addr,
  input  logic             id_use_rs,
  input  logic             id_use_rt,
  input  logic [4:0]       id_wb_addr,
  input  logic             id_regwrite,
  input  logic             id_memread,
  input  logic             id_memwrite,
  input  logic [3:0]       id_aluop,
  input  logic             flush,
  input  logic             ext_stall,
  output logic             load_use_stall,
  output logic             ex_valid,
  output logic [31:0]      ex_pc,
  output logic [31:0]      ex_ir,
  output logic [31:0]      ex_rs_data,
  output logic [31:0]      ex_rt_data,
  output logic [31:0]      ex_extdata,
  output logic [4:0]       ex_rs_addr,
  output logic [4:0]       ex_rt_addr,
  output logic [4:0]       ex_wb_addr,
  output logic             ex_regwrite,
  output logic             ex_memread,
  output logic             ex_memwrite,
  output logic [3:0]       ex_aluop
`ifdef ID_EX_STATS_EN
  ,
  output logic [CNT_W-1:0] bubble_cnt,
  output logic [CNT_W-1:0] flush_cnt,
  output logic [CNT_W-1:0] stall_cnt
`endif
);

  typedef struct packed {
    logic        valid;
    logic [31:0] pc;
    logic [31:0] ir;
    logic [31:0] rs_data;
    logic [31:0] rt_data;
    logic [31:0] extdata;
    logic [4:0]  rs_addr;
    logic [4:0]  rt_addr;
    logic [4:0]  wb_addr;
    logic        regwrite;
    logic        memread;
    logic        memwrite;
    logic [3:0]  aluop;
  } ex_bundle_t;

  ex_bundle_t bundle_q, bundle_d, id_bundle;
  logic       hazard;
  logic       rs_match, rt_match;

  assign id_bundle = '{valid: id_valid, pc: id_pc, ir: id_ir, rs_data: id_rs_data,
                       rt_data: id_rt_data, extdata: id_extdata, rs_addr: id_rs_addr,
                       rt_addr: id_rt_addr, wb_addr: id_wb_addr, regwrite: id_regwrite,
                       memread: id_memread, memwrite: id_memwrite, aluop: id_aluop};

  assign rs_match = id_use_rs && (id_rs_addr == bundle_q.wb_addr);
  assign rt_match = id_use_rt && (id_rt_addr == bundle_q.wb_addr);
  assign hazard   = bundle_q.valid && bundle_q.memread && id_valid &&
                    (bundle_q.wb_addr != 5'd0) && (rs_match || rt_match);

  // Never hold upstream against an instruction that is being killed or frozen anyway.
  assign load_use_stall = hazard && !flush && !ext_stall;

  always_comb begin
    bundle_d = bundle_q;
    if (flush)          bundle_d = '0;
    else if (ext_stall) bundle_d = bundle_q;
    else if (hazard)    bundle_d = '0;
    else                bundle_d = id_bundle;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) bundle_q <= '0;
    else     bundle_q <= bundle_d;
  end

  assign ex_valid    = bundle_q.valid;
  assign ex_pc       = bundle_q.pc;
  assign ex_ir       = bundle_q.ir;
  assign ex_rs_data  = bundle_q.rs_data;
  assign ex_rt_data  = bundle_q.rt_data;
  assign ex_extdata  = bundle_q.extdata;
  assign ex_rs_addr  = bundle_q.rs_addr;
  assign ex_rt_addr  = bundle_q.rt_addr;
  assign ex_wb_addr  = bundle_q.wb_addr;
  assign ex_regwrite = bundle_q.regwrite;
  assign ex_memread  = bundle_q.memread;
  assign ex_memwrite = bundle_q.memwrite;
  assign ex_aluop    = bundle_q.aluop;

`ifdef ID_EX_STATS_EN
  logic [CNT_W-1:0] bubble_cnt_q, flush_cnt_q, stall_cnt_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bubble_cnt_q <= '0;
      flush_cnt_q  <= '0;
      stall_cnt_q  <= '0;
    end else if (flush) begin
      if (flush_cnt_q != '1) flush_cnt_q <= flush_cnt_q + 1'b1;
    end else if (ext_stall) begin
      if (stall_cnt_q != '1) stall_cnt_q <= stall_cnt_q + 1'b1;
    end else if (hazard) begin
      if (bubble_cnt_q != '1) bubble_cnt_q <= bubble_cnt_q + 1'b1;
    end
  end

  assign bubble_cnt = bubble_cnt_q;
  assign flush_cnt  = flush_cnt_q;
  assign stall_cnt  = stall_cnt_q;
`endif

endmodule

// File: tb/tb_id_ex_reg.sv
// Randomized + directed bench for id_ex_reg against a field-level reference model.
module tb_id_ex_reg;
  localparam int CNT_W = 16;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic        id_valid, id_use_rs, id_use_rt, id_regwrite, id_memread, id_memwrite;
  logic [31:0] id_pc, id_ir, id_rs_data, id_rt_data, id_extdata;
  logic [4:0]  id_rs_addr, id_rt_addr, id_wb_addr;
  logic [3:0]  id_aluop;
  logic        flush, ext_stall, load_use_stall;
  logic        ex_valid, ex_regwrite, ex_memread, ex_memwrite;
  logic [31:0] ex_pc, ex_ir, ex_rs_data, ex_rt_data, ex_extdata;
  logic [4:0]  ex_rs_addr, ex_rt_addr, ex_wb_addr;
  logic [3:0]  ex_aluop;
`ifdef ID_EX_STATS_EN
  logic [CNT_W-1:0] bubble_cnt, flush_cnt, stall_cnt;
  int m_bub, m_fl, m_st;
`endif

  id_ex_reg #(.CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst),
    .id_valid(id_valid), .id_pc(id_pc), .id_ir(id_ir), .id_rs_data(id_rs_data),
    .id_rt_data(id_rt_data), .id_extdata(id_extdata), .id_rs_addr(id_rs_addr),
    .id_rt_addr(id_rt_addr), .id_use_rs(id_use_rs), .id_use_rt(id_use_rt),
    .id_wb_addr(id_wb_addr), .id_regwrite(id_regwrite), .id_memread(id_memread),
    .id_memwrite(id_memwrite), .id_aluop(id_aluop), .flush(flush), .ext_stall(ext_stall),
    .load_use_stall(load_use_stall), .ex_valid(ex_valid), .ex_pc(ex_pc), .ex_ir(ex_ir),
    .ex_rs_data(ex_rs_data), .ex_rt_data(ex_rt_data), .ex_extdata(ex_extdata),
    .ex_rs_addr(ex_rs_addr), .ex_rt_addr(ex_rt_addr), .ex_wb_addr(ex_wb_addr),
    .ex_regwrite(ex_regwrite), .ex_memread(ex_memread), .ex_memwrite(ex_memwrite),
    .ex_aluop(ex_aluop)
`ifdef ID_EX_STATS_EN
    , .bubble_cnt(bubble_cnt), .flush_cnt(flush_cnt), .stall_cnt(stall_cnt)
`endif
  );

  // Expected EX-stage contents, one variable per architectural field.
  logic        m_valid, m_regwrite, m_memread, m_memwrite;
  logic [31:0] m_pc, m_ir, m_rs_data, m_rt_data, m_extdata;
  logic [4:0]  m_rs_addr, m_rt_addr, m_wb_addr;
  logic [3:0]  m_aluop;

  int checks = 0;
  int passed = 0;

  task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    checks++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  function automatic logic [255:0] dut_view();
    return {ex_valid, ex_pc, ex_ir, ex_rs_data, ex_rt_data, ex_extdata, ex_rs_addr,
            ex_rt_addr, ex_wb_addr, ex_regwrite, ex_memread, ex_memwrite, ex_aluop};
  endfunction

  function automatic logic [255:0] model_view();
    return {m_valid, m_pc, m_ir, m_rs_data, m_rt_data, m_extdata, m_rs_addr,
            m_rt_addr, m_wb_addr, m_regwrite, m_memread, m_memwrite, m_aluop};
  endfunction

  task automatic model_clear();
    {m_valid, m_pc, m_ir, m_rs_data, m_rt_data, m_extdata, m_rs_addr,
     m_rt_addr, m_wb_addr, m_regwrite, m_memread, m_memwrite, m_aluop} = '0;
  endtask

  task automatic rand_id();
    id_valid    = ($urandom_range(0, 3) != 0);
    id_pc       = $urandom;
    id_ir       = $urandom;
    id_rs_data  = $urandom;
    id_rt_data  = $urandom;
    id_extdata  = $urandom;
    id_rs_addr  = 5'($urandom_range(0, 3));
    id_rt_addr  = 5'($urandom_range(0, 3));
    id_wb_addr  = 5'($urandom_range(0, 3));
    id_use_rs   = $urandom_range(0, 1) != 0;
    id_use_rt   = $urandom_range(0, 1) != 0;
    id_regwrite = $urandom_range(0, 1) != 0;
    id_memread  = $urandom_range(0, 1) != 0;
    id_memwrite = $urandom_range(0, 1) != 0;
    id_aluop    = 4'($urandom);
  endtask

  // Inputs must already be set (just after an edge); checks the combinational
  // stall mid-cycle, advances the model, then checks EX after the edge.
  task automatic step(input string tag);
    bit haz, uses_dest;
    #3;
    uses_dest = (id_use_rs && id_rs_addr == m_wb_addr) || (id_use_rt && id_rt_addr == m_wb_addr);
    haz = m_valid && m_memread && id_valid && (m_wb_addr != 0) && uses_dest;
    chk({tag, "_stall"}, 256'(load_use_stall), 256'(haz && !flush && !ext_stall));
    if (flush) begin
      model_clear();
`ifdef ID_EX_STATS_EN
      m_fl = m_fl + 1;
`endif
    end else if (ext_stall) begin
`ifdef ID_EX_STATS_EN
      m_st = m_st + 1;
`endif
    end else if (haz) begin
      model_clear();
`ifdef ID_EX_STATS_EN
      m_bub = m_bub + 1;
`endif
    end else begin
      m_valid = id_valid; m_pc = id_pc; m_ir = id_ir; m_rs_data = id_rs_data;
      m_rt_data = id_rt_data; m_extdata = id_extdata; m_rs_addr = id_rs_addr;
      m_rt_addr = id_rt_addr; m_wb_addr = id_wb_addr; m_regwrite = id_regwrite;
      m_memread = id_memread; m_memwrite = id_memwrite; m_aluop = id_aluop;
    end
    @(posedge clk); #1;
    chk({tag, "_ex"}, dut_view(), model_view());
`ifdef ID_EX_STATS_EN
    chk({tag, "_cnt"}, 256'({bubble_cnt, flush_cnt, stall_cnt}),
        256'({CNT_W'(m_bub), CNT_W'(m_fl), CNT_W'(m_st)}));
`endif
  endtask

  task automatic load_lw(input logic [4:0] dst);
    rand_id();
    id_valid = 1; id_memread = 1; id_wb_addr = dst; id_use_rs = 0; id_use_rt = 0;
    flush = 0; ext_stall = 0;
    step("lw");
  endtask

  initial begin
    logic [255:0] held;
`ifdef ID_EX_STATS_EN
    m_bub = 0; m_fl = 0; m_st = 0;
`endif
    rst = 1; flush = 0; ext_stall = 0;
    rand_id();
    model_clear();
    #1;
    chk("reset_ex", dut_view(), 256'd0);
    chk("reset_stall", 256'(load_use_stall), 256'd0);
    @(posedge clk); #1;
    rst = 0;

    // Normal flow
    rand_id();
    id_valid = 1; id_pc = 32'h400; id_extdata = 32'hFFFF8000;
    step("normal");
    chk("normal_pc", 256'(ex_pc), 256'h400);
    chk("normal_ext", 256'(ex_extdata), 256'hFFFF8000);
    chk("normal_valid", 256'(ex_valid), 256'd1);

    // Load-use hazard, then the bubble clears it
    load_lw(5'd8);
    rand_id();
    id_valid = 1; id_use_rs = 1; id_rs_addr = 5'd8; id_use_rt = 0;
    step("hazard");
    chk("hazard_bubble", 256'({ex_valid, ex_memread}), 256'd0);
    step("hazard_after");
    chk("hazard_after_valid", 256'(ex_valid), 256'd1);

    // No false hazard: r0 destination, and rs not used
    load_lw(5'd0);
    rand_id();
    id_valid = 1; id_use_rs = 1; id_rs_addr = 5'd0; id_use_rt = 0;
    step("r0_nohaz");
    load_lw(5'd8);
    rand_id();
    id_valid = 1; id_use_rs = 0; id_rs_addr = 5'd8; id_use_rt = 0;
    step("unused_nohaz");

    // Flush beats ext_stall and a pending hazard
    load_lw(5'd8);
    rand_id();
    id_valid = 1; id_use_rs = 1; id_rs_addr = 5'd8; flush = 1; ext_stall = 1;
    step("flush_prio");
    chk("flush_ctrl", 256'({ex_valid, ex_regwrite, ex_memread, ex_memwrite}), 256'd0);

    // External stall for 3 cycles while ID changes
    flush = 0; ext_stall = 0;
    rand_id(); id_valid = 1;
    step("pre_stall");
    held = dut_view();
    for (int i = 0; i < 3; i++) begin
      rand_id(); ext_stall = 1;
      step("ext_stall");
      chk("stall_hold", dut_view(), held);
    end
    ext_stall = 0;

    // Asynchronous reset mid-cycle while FULL
    rand_id(); id_valid = 1;
    step("pre_rst");
    #2 rst = 1;
    #1;
    chk("async_rst_ex", dut_view(), 256'd0);
    chk("async_rst_stall", 256'(load_use_stall), 256'd0);
    model_clear();
`ifdef ID_EX_STATS_EN
    chk("async_rst_cnt", 256'({bubble_cnt, flush_cnt, stall_cnt}), 256'd0);
    m_bub = 0; m_fl = 0; m_st = 0;
`endif
    @(posedge clk); #1;
    rst = 0;

    // Random traffic with a small register space to provoke hazards
    for (int i = 0; i < 400; i++) begin
      rand_id();
      flush     = ($urandom_range(0, 9) == 0);
      ext_stall = ($urandom_range(0, 5) == 0);
      step("rand");
    end

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end
endmodule
